// File: rtl/circular_rotator_serial_if.sv
`default_nettype none
// ============================================================================
// Module  : circular_rotator_serial_if
// Brief   : Request/response valid-ready bundle for the serial rotator.
// Revision: 1.0 - initial release
// ============================================================================
interface circular_rotator_serial_if #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
);
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [SW-1:0] in_amt;
  logic          in_dir;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;

  modport master (
    output in_valid, in_data, in_amt, in_dir, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_dir, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/circular_rotator_serial.sv
`default_nettype none
// ============================================================================
// Module  : circular_rotator_serial
// Brief   : Multi-cycle N-bit circular rotator, one bit position per clock.
// Revision: 1.0 - initial release
// ============================================================================
module circular_rotator_serial #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  wire logic                clk,
  input  wire logic                rst,
  circular_rotator_serial_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SW:0] C_N = (SW+1)'(N);

  state_t        r_state;
  logic [N-1:0]  r_data;
  logic [SW-1:0] r_count;
  logic          r_dir;

  state_t        w_next_state;
  logic [N-1:0]  w_next_data;
  logic [SW-1:0] w_next_count;
  logic          w_next_dir;
  logic [SW:0]   w_amt_ext;
  logic [SW-1:0] w_amt_mod;

  // in_amt < 2^SW < 2N, so one conditional subtract gives in_amt mod N.
  assign w_amt_ext = {1'b0, bus.in_amt};
  assign w_amt_mod = (w_amt_ext >= C_N) ? SW'(w_amt_ext - C_N) : bus.in_amt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_count <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_data  <= w_next_data;
      r_count <= w_next_count;
      r_dir   <= w_next_dir;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_data  = r_data;
    w_next_count = r_count;
    w_next_dir   = r_dir;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_next_data  = bus.in_data;
          w_next_dir   = bus.in_dir;
          w_next_count = w_amt_mod;
          w_next_state = (w_amt_mod != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        w_next_data  = r_dir ? {r_data[N-2:0], r_data[N-1]}
                             : {r_data[0], r_data[N-1:1]};
        w_next_count = r_count - SW'(1);
        if (r_count == SW'(1)) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_circular_rotator_serial.sv
`default_nettype none
// ============================================================================
// Module  : tb_circular_rotator_serial
// Brief   : Self-checking bench for N=8 and N=5 serial rotators.
// Revision: 1.0 - initial release
// ============================================================================
module tb_circular_rotator_serial;

  logic clk;
  logic rst;

  circular_rotator_serial_if #(.N(8)) bus8 ();
  circular_rotator_serial_if #(.N(5)) bus5 ();

  circular_rotator_serial #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  circular_rotator_serial #(.N(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5.slave));

  // index 0 drives the N=8 instance, index 1 the N=5 instance
  logic       iv    [2];
  logic [7:0] idata [2];
  logic [2:0] iamt  [2];
  logic       idir  [2];
  logic       ordy  [2];
  logic       rdy   [2];
  logic       vld   [2];
  logic [7:0] dout  [2];

  assign bus8.in_valid  = iv[0];
  assign bus8.in_data   = idata[0];
  assign bus8.in_amt    = iamt[0];
  assign bus8.in_dir    = idir[0];
  assign bus8.out_ready = ordy[0];
  assign bus5.in_valid  = iv[1];
  assign bus5.in_data   = idata[1][4:0];
  assign bus5.in_amt    = iamt[1];
  assign bus5.in_dir    = idir[1];
  assign bus5.out_ready = ordy[1];

  assign rdy[0]  = bus8.in_ready;
  assign vld[0]  = bus8.out_valid;
  assign dout[0] = bus8.out_data;
  assign rdy[1]  = bus5.in_ready;
  assign vld[1]  = bus5.out_valid;
  assign dout[1] = {3'b000, bus5.out_data};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Transaction-level reference: one job in flight, result known at accept.
  bit         m_busy  [2];
  bit         m_valid [2];
  int         m_wait  [2];
  logic [7:0] m_res   [2];

  function automatic int width_of(input int idx);
    return (idx == 0) ? 8 : 5;
  endfunction

  function automatic logic [7:0] rotm(input logic [7:0] x, input int k,
                                      input bit left, input int n);
    logic [7:0] y;
    y = '0;
    for (int i = 0; i < n; i++) begin
      if (left) y[(i + k) % n] = x[i];
      else      y[i]           = x[(i + k) % n];
    end
    return y;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[n=%0d]: got %0h, expected %0h", name, width_of(idx), act, exp);
    end
  endtask

  task automatic tick();
    int n;
    @(posedge clk);
    for (int j = 0; j < 2; j++) begin
      n = width_of(j);
      if (rst) begin
        m_busy[j] = 0; m_valid[j] = 0; m_wait[j] = 0; m_res[j] = '0;
      end else if (m_valid[j]) begin
        if (ordy[j]) begin
          m_valid[j] = 0; m_busy[j] = 0;
        end
      end else if (!m_busy[j]) begin
        if (iv[j]) begin
          m_wait[j]  = int'(iamt[j]) % n;
          m_res[j]   = rotm(idata[j] & 8'((1 << n) - 1), m_wait[j], idir[j], n);
          m_busy[j]  = 1;
          m_valid[j] = (m_wait[j] == 0);
        end
      end else begin
        m_wait[j]--;
        if (m_wait[j] == 0) m_valid[j] = 1;
      end
    end
    #1;
    for (int j = 0; j < 2; j++) begin
      chk("in_ready", j, rdy[j], !m_busy[j]);
      chk("out_valid", j, vld[j], m_valid[j]);
      if (m_valid[j]) chk("out_data", j, dout[j], m_res[j]);
    end
  endtask

  task automatic txn(input int idx, input logic [7:0] d, input int amt, input bit dir,
                     input int bp, output logic [7:0] res, output int lat);
    int n;
    iv[idx] = 1'b1; idata[idx] = d; iamt[idx] = 3'(amt); idir[idx] = dir;
    ordy[idx] = (bp == 0);
    n = 0;
    while (!rdy[idx] && n < 50) begin tick(); n++; end
    chk("accept_timeout", idx, rdy[idx], 1);
    tick();
    // scramble inputs: they must be ignored while busy
    iv[idx] = 1'b0; idata[idx] = 8'($urandom); iamt[idx] = 3'($urandom); idir[idx] = 1'($urandom);
    lat = 1;
    while (!vld[idx] && lat < 64) begin tick(); lat++; end
    chk("valid_timeout", idx, vld[idx], 1);
    res = dout[idx];
    if (bp > 0) begin
      iv[idx] = 1'b1;
      repeat (bp) tick();
      iv[idx] = 1'b0;
      ordy[idx] = 1'b1;
    end
    tick();
    chk("post_valid", idx, vld[idx], 0);
    chk("post_ready", idx, rdy[idx], 1);
  endtask

  initial begin
    int lat, n;
    logic [7:0] res, d, e;
    vectors = 0; miscompares = 0;
    for (int j = 0; j < 2; j++) begin
      m_busy[j] = 0; m_valid[j] = 0; m_wait[j] = 0; m_res[j] = '0;
      iv[j] = 0; idata[j] = '0; iamt[j] = '0; idir[j] = 0; ordy[j] = 1;
    end
    rst = 1'b1;
    tick();
    tick();
    for (int j = 0; j < 2; j++) begin
      chk("rst_in_ready", j, rdy[j], 1);
      chk("rst_out_valid", j, vld[j], 0);
      chk("rst_out_data", j, dout[j], 0);
    end
    rst = 1'b0;
    tick();

    txn(0, 8'b10110001, 3, 1'b0, 0, res, lat);
    chk("right3", 0, res, 8'b00110110);
    chk("right3_lat", 0, lat, 4);
    txn(0, 8'b10110001, 3, 1'b1, 0, res, lat);
    chk("left3", 0, res, 8'b10001101);
    txn(0, res, 3, 1'b0, 0, res, lat);
    chk("round_trip", 0, res, 8'b10110001);
    txn(0, 8'h5C, 7, 1'b0, 0, res, lat);
    chk("right7", 0, res, 8'hB8);
    txn(0, 8'h5C, 1, 1'b1, 0, res, lat);
    chk("left1", 0, res, 8'hB8);
    txn(0, 8'hA5, 0, 1'b0, 0, res, lat);
    chk("amt0", 0, res, 8'hA5);
    chk("amt0_lat", 0, lat, 1);
    txn(0, 8'h81, 2, 1'b0, 5, res, lat);
    chk("backpressure", 0, res, 8'h60);
    chk("backpressure_lat", 0, lat, 3);

    // reset while shifting: the in-flight job must vanish at once
    iv[0] = 1'b1; idata[0] = 8'h3C; iamt[0] = 3'd6; idir[0] = 1'b0; ordy[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 0, vld[0], 0);
    chk("rst_mid_ready", 0, rdy[0], 1);
    tick();
    rst = 1'b0;
    tick();
    txn(0, 8'h01, 1, 1'b1, 0, res, lat);
    chk("after_reset", 0, res, 8'h02);
    chk("after_reset_lat", 0, lat, 2);

    txn(1, 8'b00010011, 7, 1'b0, 0, res, lat);
    chk("n5_wrap", 1, res, 8'b00011100);
    chk("n5_wrap_lat", 1, lat, 3);

    for (int idx = 0; idx < 2; idx++) begin
      n = width_of(idx);
      for (int rep = 0; rep < 2; rep++) begin
        for (int a = 0; a < 8; a++) begin
          for (int dr = 0; dr < 2; dr++) begin
            d = 8'($urandom) & 8'((1 << n) - 1);
            e = rotm(d, a % n, 1'(dr), n);
            txn(idx, d, a, 1'(dr), int'($urandom_range(0, 3)), res, lat);
            chk("sweep_data", idx, res, e);
            chk("sweep_lat", idx, lat, (a % n) + 1);
          end
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
